videoaxis2rgb: RTL and testbench

Converts an AXI4-Stream video input (24-bit pixels, tuser = start of frame, tlast = end of line) into parallel RGB video with hsync, vsync_n and de for the display or encoder side of the vision pipeline. It is the transmit-side counterpart of the RGB-to-AXIS capture path. A free-running raster timing generator sets the pixel rate. The block aligns the incoming stream to the raster frame start and flags stream errors. Default timing is 1600x900 reduced blanking (1800x1000 total).

---
 rtl/videoaxis2rgb.sv | 136 +++++++++++++
 tb/tb_videoaxis2rgb.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/videoaxis2rgb.sv
`default_nettype none
// ============================================================================
// Module   : videoaxis2rgb
// Brief    : AXI4-Stream video to parallel RGB with hsync/vsync_n/de, locking
//            the incoming stream to a free-running raster timing generator.
// Revision : 1.0 - initial release
// ============================================================================
module videoaxis2rgb #(
    parameter int H_ACTIVE = 1600,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 80,
    parameter int H_BP     = 96,
    parameter int V_ACTIVE = 900,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 96
) (
    input  logic        vid_clk,
    input  logic        rst_n,
    input  logic [23:0] s_axis_tdata,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        hsync,
    output logic        vsync_n,
    output logic        de,
    output logic [23:0] rgb_data,
    output logic        locked,
    output logic        underflow,
    output logic        misalign
);

    localparam logic [11:0] c_H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] c_H_LAST   = 12'(H_ACTIVE - 1);
    localparam logic [11:0] c_H_TOTAL  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] c_HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] c_V_TOTAL  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] c_VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_HUNT     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_STREAM   = 2'd2
    } state_t;

    state_t      r_state;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic        r_hsync;
    logic        r_vsync_n;
    logic        r_de;
    logic [23:0] r_rgb;
    logic        r_locked;
    logic        r_underflow;
    logic        r_misalign;

    logic w_active;
    logic w_hs;
    logic w_vs;
    logic w_sof;
    logic w_eol;
    logic w_stream;
    logic w_uf;
    logic w_mis;

    assign w_active = (r_x < c_H_ACT) && (r_y < c_V_ACT);
    assign w_hs     = (r_x >= c_HS_START) && (r_x < c_HS_END);
    assign w_vs     = (r_y >= c_VS_START) && (r_y < c_VS_END);
    assign w_sof    = (r_x == 12'd0) && (r_y == 12'd0);
    assign w_eol    = (r_x == c_H_LAST);

    // WAIT_SOF behaves as STREAM on the raster origin cycle so the SOF beat
    // is consumed and shown at pixel 0/0 without a frame of extra delay.
    assign w_stream = (r_state == ST_STREAM) || ((r_state == ST_WAIT_SOF) && w_sof);
    assign w_uf     = w_stream && w_active && !s_axis_tvalid;
    assign w_mis    = w_stream && w_active && s_axis_tvalid &&
                      ((s_axis_tuser != w_sof) || (s_axis_tlast != w_eol));

    assign s_axis_tready = rst_n &&
                           ((r_state == ST_HUNT) ? (s_axis_tvalid && !s_axis_tuser)
                                                 : (w_stream && w_active));

    always_ff @(posedge vid_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= 12'd0;
            r_y <= 12'd0;
        end else if (r_x == c_H_TOTAL - 12'd1) begin
            r_x <= 12'd0;
            r_y <= (r_y == c_V_TOTAL - 12'd1) ? 12'd0 : r_y + 12'd1;
        end else begin
            r_x <= r_x + 12'd1;
        end
    end

    always_ff @(posedge vid_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_HUNT;
            r_hsync     <= 1'b0;
            r_vsync_n   <= 1'b1;
            r_de        <= 1'b0;
            r_rgb       <= 24'd0;
            r_locked    <= 1'b0;
            r_underflow <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_hsync     <= w_hs;
            r_vsync_n   <= !w_vs;
            r_de        <= w_active;
            r_rgb       <= (w_stream && w_active && s_axis_tvalid) ? s_axis_tdata : 24'd0;
            r_locked    <= w_stream;
            r_underflow <= w_uf;
            r_misalign  <= w_mis;

            if (r_state == ST_HUNT) begin
                if (s_axis_tvalid && s_axis_tuser)
                    r_state <= ST_WAIT_SOF;
            end else if (w_stream) begin
                r_state <= (w_uf || w_mis) ? ST_HUNT : ST_STREAM;
            end
        end
    end

    assign hsync     = r_hsync;
    assign vsync_n   = r_vsync_n;
    assign de        = r_de;
    assign rgb_data  = r_rgb;
    assign locked    = r_locked;
    assign underflow = r_underflow;
    assign misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_videoaxis2rgb.sv
`default_nettype none
// ============================================================================
// Module   : tb_videoaxis2rgb
// Brief    : Randomized stimulus against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_videoaxis2rgb;

    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FRAME = HT * VT;
    localparam int BEATS = 8 * 4;

    logic        vid_clk = 1'b0;
    logic        rst_n;
    logic [23:0] tdata;
    logic        tuser, tlast, tvalid;
    logic        tready, hsync, vsync_n, de, locked, underflow, misalign;
    logic [23:0] rgb;

    int n_vec = 0;
    int n_err = 0;

    // Model: raster cycle index, lock mode (0 hunting, 1 armed, 2 locked),
    // and the source's head beat index within its frame.
    int          c;
    int          mode;
    int          sp;
    logic [23:0] head_data;
    bit          rnd_gaps, inj_uf, inj_tl, inj_tu;

    videoaxis2rgb #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .vid_clk      (vid_clk),
        .rst_n        (rst_n),
        .s_axis_tdata (tdata),
        .s_axis_tuser (tuser),
        .s_axis_tlast (tlast),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(tready),
        .hsync        (hsync),
        .vsync_n      (vsync_n),
        .de           (de),
        .rgb_data     (rgb),
        .locked       (locked),
        .underflow    (underflow),
        .misalign     (misalign)
    );

    always #5 vid_clk = ~vid_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_hsync"}, hsync, 0);
        check_val({tag, "_vsync_n"}, vsync_n, 1);
        check_val({tag, "_de"}, de, 0);
        check_val({tag, "_rgb"}, rgb, 0);
        check_val({tag, "_tready"}, tready, 0);
        check_val({tag, "_locked"}, locked, 0);
        check_val({tag, "_underflow"}, underflow, 0);
        check_val({tag, "_misalign"}, misalign, 0);
    endtask

    // One pixel clock: drive the source, check tready, then check the
    // registered outputs one edge later.
    task automatic step();
        int x, y;
        bit act, sof, eol, eff, tv, tu, tl, rdy, bad;
        logic [23:0] d, e_rgb;
        x   = c % HT;
        y   = c / HT;
        act = (x < 8) && (y < 4);
        sof = (c == 0);
        eol = (x == 7);
        eff = (mode == 2) || (mode == 1 && sof);
        tv  = rnd_gaps ? ($urandom_range(0, 15) != 0) : 1'b1;
        tu  = (sp == 0);
        tl  = (sp % 8 == 7);
        d   = head_data;
        if (inj_uf && eff && act && x == 4 && y == 2) begin tv = 0; inj_uf = 0; end
        if (inj_tl && eff && act && x == 6) begin tl = 1; inj_tl = 0; end
        if (inj_tu && eff && act && x == 0 && y == 1) begin tu = 1; inj_tu = 0; end
        tvalid = tv; tuser = tu; tlast = tl; tdata = d;
        rdy = (mode == 0) ? (tv && !tu) : (eff && act);
        bad = eff && act && tv && ((tu != sof) || (tl != eol));
        e_rgb = (eff && act && tv) ? d : 24'd0;
        #1;
        check_val("tready", tready, rdy);
        @(posedge vid_clk);
        #1;
        check_val("de", de, act);
        check_val("hsync", hsync, (x >= 10 && x < 12));
        check_val("vsync_n", vsync_n, (y != 5));
        check_val("rgb", rgb, e_rgb);
        check_val("locked", locked, eff);
        check_val("underflow", underflow, eff && act && !tv);
        check_val("misalign", misalign, bad);
        if (rdy && tv) begin
            sp = (sp + 1) % BEATS;
            head_data = 24'($urandom);
        end
        if (mode == 0) begin
            if (tv && tu) mode = 1;
        end else if (eff) begin
            mode = (act && (!tv || bad)) ? 0 : 2;
        end
        c = (c + 1) % FRAME;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 1'b0; tvalid = 0; tuser = 0; tlast = 0; tdata = '0;
        rnd_gaps = 0; inj_uf = 0; inj_tl = 0; inj_tu = 0;
        sp = 0; head_data = 24'($urandom);
        repeat (3) @(posedge vid_clk);
        #1;
        check_reset_outputs("reset");
        @(negedge vid_clk);
        rst_n = 1'b1; c = 0; mode = 0;

        run(3 * FRAME);

        inj_uf = 1;
        run(3 * FRAME);
        check_val("uf_injected", inj_uf, 0);

        inj_tl = 1;
        run(3 * FRAME);
        check_val("tl_injected", inj_tl, 0);

        inj_tu = 1;
        run(3 * FRAME);
        check_val("tu_injected", inj_tu, 0);

        // Asynchronous reset mid-line while locked, then a mid-frame start.
        for (int i = 0; i < 3 * FRAME && !(mode == 2 && c == HT + 3); i++) step();
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge vid_clk);
        rst_n = 1'b1; c = 0; mode = 0; sp = BEATS / 4 + 3; head_data = 24'($urandom);
        run(3 * FRAME);

        rnd_gaps = 1;
        run(4 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
